// File: rtl/mc_port_responder.sv
// Behavioral single-port MC responder: services personality mc_rq_* requests against a
// word-addressed array and returns in-order mc_rs_* responses after a fixed latency.
module mc_port_responder #(
  parameter int unsigned RTNCTL_WIDTH = 32,
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned LATENCY      = 4,
  parameter int unsigned QDEPTH       = 8
) (
  input  logic                    clk,
  input  logic                    i_reset,
  input  logic                    mc_rq_vld,
  input  logic [2:0]              mc_rq_cmd,
  input  logic [3:0]              mc_rq_scmd,
  input  logic [1:0]              mc_rq_size,
  input  logic [47:0]             mc_rq_vadr,
  input  logic [63:0]             mc_rq_data,
  input  logic [RTNCTL_WIDTH-1:0] mc_rq_rtnctl,
  output logic                    mc_rq_stall,
  input  logic                    mc_rq_flush,
  output logic                    mc_rs_vld,
  output logic [2:0]              mc_rs_cmd,
  output logic [3:0]              mc_rs_scmd,
  output logic [63:0]             mc_rs_data,
  output logic [RTNCTL_WIDTH-1:0] mc_rs_rtnctl,
  input  logic                    mc_rs_stall,
  output logic                    mc_rs_flush_cmplt,
  output logic                    o_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned PW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned OW    = $clog2(QDEPTH + 1);
  localparam int unsigned NSTG  = LATENCY - 1;

  localparam logic [2:0] RQ_RD  = 3'd1;
  localparam logic [2:0] RQ_WR  = 3'd2;
  localparam logic [2:0] RS_RD  = 3'd2;
  localparam logic [2:0] RS_WR  = 3'd3;
  localparam logic [2:0] RS_ERR = 3'd0;

  typedef struct packed {
    logic [2:0]              cmd;
    logic [3:0]              scmd;
    logic [63:0]             data;
    logic [RTNCTL_WIDTH-1:0] rtnctl;
  } ent_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PEND = 2'd1,
    S_DONE = 2'd2
  } fl_state_t;

  logic [63:0]       r_mem [DEPTH];
  ent_t              r_fifo [QDEPTH];
  logic [PW-1:0]     r_wp;
  logic [PW-1:0]     r_rp;
  logic [OW-1:0]     r_cnt;
  logic [OW-1:0]     r_occ;
  fl_state_t         r_state;
  fl_state_t         w_state_nxt;
  logic              r_err;

  logic              w_acc;
  logic              w_pop;
  logic              w_push;
  ent_t              w_push_ent;
  ent_t              w_ent;
  ent_t              w_head;
  logic              w_is_rd;
  logic              w_is_wr;
  logic [ADDR_W-1:0] w_idx;
  logic [63:0]       w_old;
  logic [63:0]       w_wr_word;
  logic [3:0]        w_lo;
  logic [3:0]        w_hi;
  logic              w_unused;

  assign w_acc    = mc_rq_vld && !mc_rq_stall;
  assign w_pop    = mc_rs_vld && !mc_rs_stall;
  assign w_idx    = mc_rq_vadr[ADDR_W+2:3];
  assign w_is_rd  = (mc_rq_cmd == RQ_RD);
  assign w_is_wr  = (mc_rq_cmd == RQ_WR);
  assign w_old    = r_mem[w_idx];
  assign w_unused = ^mc_rq_vadr[47:ADDR_W+3];

  // Byte-lane merge; lanes past byte 7 simply never match.
  always_comb begin
    w_lo      = {1'b0, mc_rq_vadr[2:0]};
    w_hi      = w_lo + (4'd1 << mc_rq_size);
    w_wr_word = w_old;
    for (int b = 0; b < 8; b++) begin
      if ((4'(b) >= w_lo) && (4'(b) < w_hi)) begin
        w_wr_word[b*8 +: 8] = mc_rq_data[b*8 +: 8];
      end
    end
  end

  always_comb begin
    w_ent.scmd   = mc_rq_scmd;
    w_ent.rtnctl = mc_rq_rtnctl;
    w_ent.cmd    = RS_ERR;
    w_ent.data   = '0;
    if (w_is_rd) begin
      w_ent.cmd  = RS_RD;
      w_ent.data = w_old;
    end else if (w_is_wr) begin
      w_ent.cmd  = RS_WR;
    end
  end

  // Array contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (w_acc && w_is_wr && !i_reset) begin
      r_mem[w_idx] <= w_wr_word;
    end
  end

  // Fixed-latency delay line; the FIFO write itself supplies the final cycle.
  if (NSTG > 0) begin : g_pipe
    logic r_pv [NSTG];
    ent_t r_pe [NSTG];

    always_ff @(posedge clk) begin
      if (i_reset) begin
        for (int i = 0; i < NSTG; i++) r_pv[i] <= 1'b0;
      end else begin
        r_pv[0] <= w_acc;
        for (int i = 1; i < NSTG; i++) r_pv[i] <= r_pv[i-1];
      end
    end

    always_ff @(posedge clk) begin
      r_pe[0] <= w_ent;
      for (int i = 1; i < NSTG; i++) r_pe[i] <= r_pe[i-1];
    end

    assign w_push     = r_pv[NSTG-1];
    assign w_push_ent = r_pe[NSTG-1];
  end else begin : g_nopipe
    assign w_push     = w_acc;
    assign w_push_ent = w_ent;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wp] <= w_push_ent;
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_occ <= '0;
    end else begin
      if (w_push) r_wp <= (r_wp == PW'(QDEPTH - 1)) ? '0 : r_wp + PW'(1);
      if (w_pop)  r_rp <= (r_rp == PW'(QDEPTH - 1)) ? '0 : r_rp + PW'(1);
      r_cnt <= r_cnt + OW'(w_push) - OW'(w_pop);
      r_occ <= r_occ + OW'(w_acc) - OW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_err <= 1'b0;
    end else if (w_acc && !w_is_rd && !w_is_wr) begin
      r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Flush sequencing plus request back-pressure.
  always_comb begin
    w_state_nxt       = r_state;
    mc_rq_stall       = 1'b0;
    mc_rs_flush_cmplt = 1'b0;
    case (r_state)
      S_IDLE: if (mc_rq_flush) w_state_nxt = S_PEND;
      S_PEND: if (r_occ == '0) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if ((r_occ == OW'(QDEPTH)) || (r_state != S_IDLE)) mc_rq_stall = 1'b1;
    if (r_state == S_DONE) mc_rs_flush_cmplt = 1'b1;
  end

  assign w_head       = r_fifo[r_rp];
  assign mc_rs_vld    = (r_cnt != '0);
  assign mc_rs_cmd    = mc_rs_vld ? w_head.cmd    : '0;
  assign mc_rs_scmd   = mc_rs_vld ? w_head.scmd   : '0;
  assign mc_rs_data   = mc_rs_vld ? w_head.data   : '0;
  assign mc_rs_rtnctl = mc_rs_vld ? w_head.rtnctl : '0;
  assign o_err        = r_err;

endmodule

// File: tb/tb_mc_port_responder.sv
// Directed self-checking bench for mc_port_responder (default parameters).
module tb_mc_port_responder;

  logic        clk;
  logic        i_reset;
  logic        mc_rq_vld;
  logic [2:0]  mc_rq_cmd;
  logic [3:0]  mc_rq_scmd;
  logic [1:0]  mc_rq_size;
  logic [47:0] mc_rq_vadr;
  logic [63:0] mc_rq_data;
  logic [31:0] mc_rq_rtnctl;
  logic        mc_rq_stall;
  logic        mc_rq_flush;
  logic        mc_rs_vld;
  logic [2:0]  mc_rs_cmd;
  logic [3:0]  mc_rs_scmd;
  logic [63:0] mc_rs_data;
  logic [31:0] mc_rs_rtnctl;
  logic        mc_rs_stall;
  logic        mc_rs_flush_cmplt;
  logic        o_err;

  int checks;
  int failures;

  mc_port_responder dut (
    .clk               (clk),
    .i_reset           (i_reset),
    .mc_rq_vld         (mc_rq_vld),
    .mc_rq_cmd         (mc_rq_cmd),
    .mc_rq_scmd        (mc_rq_scmd),
    .mc_rq_size        (mc_rq_size),
    .mc_rq_vadr        (mc_rq_vadr),
    .mc_rq_data        (mc_rq_data),
    .mc_rq_rtnctl      (mc_rq_rtnctl),
    .mc_rq_stall       (mc_rq_stall),
    .mc_rq_flush       (mc_rq_flush),
    .mc_rs_vld         (mc_rs_vld),
    .mc_rs_cmd         (mc_rs_cmd),
    .mc_rs_scmd        (mc_rs_scmd),
    .mc_rs_data        (mc_rs_data),
    .mc_rs_rtnctl      (mc_rs_rtnctl),
    .mc_rs_stall       (mc_rs_stall),
    .mc_rs_flush_cmplt (mc_rs_flush_cmplt),
    .o_err             (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_rq;
    mc_rq_vld = 1'b0; mc_rq_cmd = '0; mc_rq_scmd = '0; mc_rq_size = '0;
    mc_rq_vadr = '0; mc_rq_data = '0; mc_rq_rtnctl = '0;
  endtask

  task automatic drive_rq(input logic [2:0] cmd, input logic [3:0] scmd, input logic [1:0] size,
                          input logic [47:0] adr, input logic [63:0] data, input logic [31:0] tag);
    mc_rq_vld = 1'b1; mc_rq_cmd = cmd; mc_rq_scmd = scmd; mc_rq_size = size;
    mc_rq_vadr = adr; mc_rq_data = data; mc_rq_rtnctl = tag;
  endtask

  // One request, wait for its response, capture it, then consume it.
  task automatic txn(input logic [2:0] cmd, input logic [1:0] size, input logic [47:0] adr,
                     input logic [63:0] data, input logic [31:0] tag, output bit ok,
                     output logic [2:0] rcmd, output logic [3:0] rscmd,
                     output logic [63:0] rdata, output logic [31:0] rtag);
    bit acc;
    bit got;
    acc = 1'b0; got = 1'b0;
    drive_rq(cmd, 4'hA, size, adr, data, tag);
    for (int i = 0; i < 50; i++) begin
      if (!mc_rq_stall) begin acc = 1'b1; tick; break; end
      tick;
    end
    idle_rq;
    for (int i = 0; i < 50; i++) begin
      if (mc_rs_vld) begin got = 1'b1; break; end
      tick;
    end
    ok = acc && got;
    rcmd = mc_rs_cmd; rscmd = mc_rs_scmd; rdata = mc_rs_data; rtag = mc_rs_rtnctl;
    if (got) tick;
  endtask

  task automatic test_reset;
    i_reset = 1'b1; mc_rs_stall = 1'b0; mc_rq_flush = 1'b0; idle_rq;
    tick; tick;
    checks++; if (mc_rq_stall !== 1'b0) begin failures++; $display("FAIL rst_rq_stall got=%b exp=0", mc_rq_stall); end
    checks++; if (mc_rs_vld !== 1'b0) begin failures++; $display("FAIL rst_rs_vld got=%b exp=0", mc_rs_vld); end
    checks++; if (mc_rs_cmd !== 3'd0) begin failures++; $display("FAIL rst_rs_cmd got=%0d exp=0", mc_rs_cmd); end
    checks++; if (mc_rs_data !== 64'd0) begin failures++; $display("FAIL rst_rs_data got=%h exp=0", mc_rs_data); end
    checks++; if (mc_rs_rtnctl !== 32'd0) begin failures++; $display("FAIL rst_rs_rtnctl got=%h exp=0", mc_rs_rtnctl); end
    checks++; if (mc_rs_flush_cmplt !== 1'b0) begin failures++; $display("FAIL rst_cmplt got=%b exp=0", mc_rs_flush_cmplt); end
    checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", o_err); end
    i_reset = 1'b0;
    tick;
  endtask

  task automatic test_write_read;
    drive_rq(3'd2, 4'd1, 2'd3, 48'h40, 64'h1122334455667788, 32'd5);
    checks++; if (mc_rq_stall !== 1'b0) begin failures++; $display("FAIL wr_rq_stall got=%b exp=0", mc_rq_stall); end
    tick;
    drive_rq(3'd1, 4'd2, 2'd3, 48'h40, 64'd0, 32'd6);
    tick;
    idle_rq;
    tick;
    checks++; if (mc_rs_vld !== 1'b0) begin failures++; $display("FAIL wr_early_vld got=%b exp=0", mc_rs_vld); end
    tick;
    checks++; if (mc_rs_vld !== 1'b1) begin failures++; $display("FAIL wr_rs_vld got=%b exp=1", mc_rs_vld); end
    checks++; if (mc_rs_cmd !== 3'd3) begin failures++; $display("FAIL wr_rs_cmd got=%0d exp=3", mc_rs_cmd); end
    checks++; if (mc_rs_rtnctl !== 32'd5) begin failures++; $display("FAIL wr_rs_tag got=%0d exp=5", mc_rs_rtnctl); end
    checks++; if (mc_rs_scmd !== 4'd1) begin failures++; $display("FAIL wr_rs_scmd got=%0d exp=1", mc_rs_scmd); end
    checks++; if (mc_rs_data !== 64'd0) begin failures++; $display("FAIL wr_rs_data got=%h exp=0", mc_rs_data); end
    tick;
    checks++; if (mc_rs_vld !== 1'b1) begin failures++; $display("FAIL rd_rs_vld got=%b exp=1", mc_rs_vld); end
    checks++; if (mc_rs_cmd !== 3'd2) begin failures++; $display("FAIL rd_rs_cmd got=%0d exp=2", mc_rs_cmd); end
    checks++; if (mc_rs_data !== 64'h1122334455667788) begin failures++; $display("FAIL rd_rs_data got=%h exp=1122334455667788", mc_rs_data); end
    checks++; if (mc_rs_rtnctl !== 32'd6) begin failures++; $display("FAIL rd_rs_tag got=%0d exp=6", mc_rs_rtnctl); end
    tick;
    checks++; if (mc_rs_vld !== 1'b0) begin failures++; $display("FAIL rd_after_vld got=%b exp=0", mc_rs_vld); end
  endtask

  task automatic test_byte_lanes;
    bit ok; logic [2:0] c; logic [3:0] s; logic [63:0] d; logic [31:0] t;
    txn(3'd2, 2'd3, 48'h40, 64'd0, 32'd7, ok, c, s, d, t);
    checks++; if (!ok || c !== 3'd3) begin failures++; $display("FAIL bl_clear ok=%b cmd=%0d exp=3", ok, c); end
    txn(3'd2, 2'd0, 48'h43, 64'h00000000AB000000, 32'd8, ok, c, s, d, t);
    checks++; if (!ok || t !== 32'd8) begin failures++; $display("FAIL bl_byte_wr ok=%b tag=%0d exp=8", ok, t); end
    txn(3'd1, 2'd3, 48'h40, 64'd0, 32'd9, ok, c, s, d, t);
    checks++; if (!ok || d !== 64'h00000000AB000000) begin failures++; $display("FAIL bl_byte_rd ok=%b got=%h exp=00000000ab000000", ok, d); end
    txn(3'd2, 2'd2, 48'h46, 64'hFFEE000000000099, 32'd10, ok, c, s, d, t);
    checks++; if (!ok || c !== 3'd3) begin failures++; $display("FAIL bl_edge_wr ok=%b cmd=%0d exp=3", ok, c); end
    txn(3'd1, 2'd3, 48'h2040, 64'd0, 32'd11, ok, c, s, d, t);
    checks++; if (!ok || d !== 64'hFFEE0000AB000000) begin failures++; $display("FAIL bl_alias_rd ok=%b got=%h exp=ffee0000ab000000", ok, d); end
    checks++; if (c !== 3'd2 || t !== 32'd11) begin failures++; $display("FAIL bl_alias_hdr cmd=%0d tag=%0d exp=2/11", c, t); end
  endtask

  task automatic test_back_to_back;
    for (int c = 0; c < 12; c++) begin
      if (c < 6) drive_rq(3'd1, 4'd0, 2'd3, 48'h40, 64'd0, 32'(200 + c));
      else idle_rq;
      if (c < 6) begin
        checks++; if (mc_rq_stall !== 1'b0) begin failures++; $display("FAIL b2b_stall c=%0d got=%b exp=0", c, mc_rq_stall); end
      end
      if (c >= 4 && c < 10) begin
        checks++;
        if (mc_rs_vld !== 1'b1 || mc_rs_rtnctl !== 32'(200 + c - 4) || mc_rs_cmd !== 3'd2) begin
          failures++; $display("FAIL b2b_rs c=%0d vld=%b tag=%0d cmd=%0d exp=1/%0d/2", c, mc_rs_vld, mc_rs_rtnctl, mc_rs_cmd, 200 + c - 4);
        end
      end else begin
        checks++; if (mc_rs_vld !== 1'b0) begin failures++; $display("FAIL b2b_idle c=%0d vld=%b exp=0", c, mc_rs_vld); end
      end
      tick;
    end
  endtask

  task automatic test_backpressure;
    int n;
    int got;
    n = 0; got = 0;
    mc_rs_stall = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (n < 10) drive_rq(3'd1, 4'd0, 2'd3, 48'h40, 64'd0, 32'(300 + n));
      else idle_rq;
      if (mc_rq_vld && !mc_rq_stall) n++;
      tick;
    end
    idle_rq;
    checks++; if (n !== 8) begin failures++; $display("FAIL bp_accepts got=%0d exp=8", n); end
    checks++; if (mc_rq_stall !== 1'b1) begin failures++; $display("FAIL bp_stall got=%b exp=1", mc_rq_stall); end
    checks++; if (mc_rs_vld !== 1'b1 || mc_rs_rtnctl !== 32'd300) begin failures++; $display("FAIL bp_head vld=%b tag=%0d exp=1/300", mc_rs_vld, mc_rs_rtnctl); end
    tick;
    checks++; if (mc_rs_rtnctl !== 32'd300 || mc_rs_cmd !== 3'd2) begin failures++; $display("FAIL bp_hold tag=%0d cmd=%0d exp=300/2", mc_rs_rtnctl, mc_rs_cmd); end
    mc_rs_stall = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (got >= 10) break;
      if (n < 10) drive_rq(3'd1, 4'd0, 2'd3, 48'h40, 64'd0, 32'(300 + n));
      else idle_rq;
      if (mc_rq_vld && !mc_rq_stall) n++;
      if (mc_rs_vld) begin
        checks++; if (mc_rs_rtnctl !== 32'(300 + got)) begin failures++; $display("FAIL bp_order idx=%0d got=%0d exp=%0d", got, mc_rs_rtnctl, 300 + got); end
        got++;
      end
      tick;
    end
    idle_rq;
    checks++; if (got !== 10 || n !== 10) begin failures++; $display("FAIL bp_count rsp=%0d acc=%0d exp=10/10", got, n); end
    tick; tick; tick; tick; tick;
    checks++; if (mc_rs_vld !== 1'b0) begin failures++; $display("FAIL bp_dup vld=%b exp=0", mc_rs_vld); end
  endtask

  task automatic test_flush_inflight;
    int nrs;
    nrs = 0;
    for (int c = 0; c < 13; c++) begin
      if (c < 3) drive_rq(3'd2, 4'd0, 2'd3, 48'h80, 64'h0123456789ABCDEF, 32'(400 + c));
      else idle_rq;
      mc_rq_flush = (c == 2);
      checks++;
      if (mc_rq_stall !== ((c >= 3 && c <= 8) ? 1'b1 : 1'b0)) begin
        failures++; $display("FAIL fl_stall c=%0d got=%b", c, mc_rq_stall);
      end
      checks++;
      if (mc_rs_flush_cmplt !== ((c == 8) ? 1'b1 : 1'b0)) begin
        failures++; $display("FAIL fl_cmplt c=%0d got=%b", c, mc_rs_flush_cmplt);
      end
      if (c >= 4 && c <= 6) begin
        checks++;
        if (mc_rs_vld !== 1'b1 || mc_rs_cmd !== 3'd3 || mc_rs_rtnctl !== 32'(400 + c - 4)) begin
          failures++; $display("FAIL fl_rs c=%0d vld=%b cmd=%0d tag=%0d exp=1/3/%0d", c, mc_rs_vld, mc_rs_cmd, mc_rs_rtnctl, 400 + c - 4);
        end
      end
      if (mc_rs_vld) nrs++;
      tick;
    end
    mc_rq_flush = 1'b0;
    checks++; if (nrs !== 3) begin failures++; $display("FAIL fl_rs_count got=%0d exp=3", nrs); end
  endtask

  task automatic test_flush_idle;
    for (int c = 0; c < 6; c++) begin
      mc_rq_flush = (c <= 2);
      checks++;
      if (mc_rs_flush_cmplt !== ((c == 2) ? 1'b1 : 1'b0)) begin
        failures++; $display("FAIL fi_cmplt c=%0d got=%b", c, mc_rs_flush_cmplt);
      end
      checks++;
      if (mc_rq_stall !== ((c == 1 || c == 2) ? 1'b1 : 1'b0)) begin
        failures++; $display("FAIL fi_stall c=%0d got=%b", c, mc_rq_stall);
      end
      tick;
    end
    mc_rq_flush = 1'b0;
  endtask

  task automatic test_err;
    bit ok; logic [2:0] c; logic [3:0] s; logic [63:0] d; logic [31:0] t;
    checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL err_pre got=%b exp=0", o_err); end
    txn(3'd5, 2'd3, 48'h40, 64'hDEADBEEF, 32'h55, ok, c, s, d, t);
    checks++; if (!ok || c !== 3'd0) begin failures++; $display("FAIL err_cmd ok=%b got=%0d exp=0", ok, c); end
    checks++; if (d !== 64'd0 || t !== 32'h55 || s !== 4'hA) begin failures++; $display("FAIL err_rs data=%h tag=%h scmd=%h exp=0/55/a", d, t, s); end
    checks++; if (o_err !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", o_err); end
    txn(3'd1, 2'd3, 48'h40, 64'd0, 32'd12, ok, c, s, d, t);
    checks++; if (!ok || d !== 64'hFFEE0000AB000000) begin failures++; $display("FAIL err_nowrite ok=%b got=%h exp=ffee0000ab000000", ok, d); end
    checks++; if (o_err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", o_err); end
  endtask

  task automatic test_reset_inflight;
    bit seen;
    for (int c = 0; c < 4; c++) begin
      drive_rq(3'd1, 4'd0, 2'd3, 48'h40, 64'd0, 32'(500 + c));
      tick;
    end
    idle_rq;
    checks++; if (mc_rs_vld !== 1'b1 || mc_rs_rtnctl !== 32'd500) begin failures++; $display("FAIL ri_pre vld=%b tag=%0d exp=1/500", mc_rs_vld, mc_rs_rtnctl); end
    i_reset = 1'b1;
    tick;
    checks++; if (mc_rs_vld !== 1'b0 || mc_rs_cmd !== 3'd0) begin failures++; $display("FAIL ri_vld vld=%b cmd=%0d exp=0/0", mc_rs_vld, mc_rs_cmd); end
    checks++; if (mc_rs_data !== 64'd0 || mc_rs_rtnctl !== 32'd0) begin failures++; $display("FAIL ri_data data=%h tag=%h exp=0/0", mc_rs_data, mc_rs_rtnctl); end
    checks++; if (o_err !== 1'b0 || mc_rq_stall !== 1'b0 || mc_rs_flush_cmplt !== 1'b0) begin failures++; $display("FAIL ri_ctl err=%b stall=%b cmplt=%b exp=0/0/0", o_err, mc_rq_stall, mc_rs_flush_cmplt); end
    i_reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (mc_rs_vld) seen = 1'b1;
      tick;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL ri_stale got=%b exp=0", seen); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset;
    test_write_read;
    test_byte_lanes;
    test_back_to_back;
    test_backpressure;
    test_flush_inflight;
    test_flush_idle;
    test_err;
    test_reset_inflight;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_port_responder.md
# mc_port_responder

Single-port behavioral memory-controller responder for the personality MC interface. Accepts `mc_rq_*` requests from one personality port, services them against an internal word-addressed array, and returns in-order `mc_rs_*` responses after a fixed latency with rtnctl echoed. It also answers write flushes. Used as the MC side in personality-level simulation benches and as a loopback memory in bring-up builds.

## Interface
Parameters:
- `RTNCTL_WIDTH`, 32, width of request/response return-control tag
- `ADDR_W`, 10, log2 of array depth in 64-bit words
- `LATENCY`, 4, request-accept to response-eligible delay in cycles (>=1)
- `QDEPTH`, 8, max requests in flight (pipeline plus response queue), power of 2, >= LATENCY

Ports:
- `clk`  in  1  clock; one clock domain
- `i_reset`  in  1  synchronous, active-high reset
- `mc_rq_vld`  in  1  request valid
- `mc_rq_cmd`  in  3  1 = read, 2 = write, others unsupported
- `mc_rq_scmd`  in  4  sub-command, echoed in response
- `mc_rq_size`  in  2  0/1/2/3 = 1/2/4/8 bytes
- `mc_rq_vadr`  in  48  byte address
- `mc_rq_data`  in  64  write data, lane-aligned to vadr[2:0]
- `mc_rq_rtnctl`  in  RTNCTL_WIDTH  tag
- `mc_rq_stall`  out  1  responder cannot accept this cycle
- `mc_rq_flush`  in  1  write-flush request pulse
- `mc_rs_vld`  out  1  response valid
- `mc_rs_cmd`  out  3  2 = read data, 3 = write complete, 0 = error
- `mc_rs_scmd`  out  4  echoed scmd
- `mc_rs_data`  out  64  read data (0 for non-reads)
- `mc_rs_rtnctl`  out  RTNCTL_WIDTH  echoed tag
- `mc_rs_stall`  in  1  personality cannot take a response
- `mc_rs_flush_cmplt`  out  1  one-cycle flush-complete pulse
- `o_err`  out  1  sticky: unsupported cmd seen

## Operation
- Transfer rule: request accepted iff `mc_rq_vld && !mc_rq_stall`; response consumed iff `mc_rs_vld && !mc_rs_stall`.
- Word index = vadr[ADDR_W+2:3]; upper bits ignored (aliasing).
- Write: at accept, byte lanes vadr[2:0] .. vadr[2:0]+2^size-1 of the word updated from matching lanes of `mc_rq_data`; lanes beyond byte 7 dropped. Response cmd 3.
- Read: at accept, full aligned 64-bit word captured (includes same-cycle-earlier writes, i.e. any write accepted before). Response cmd 2.
- Unsupported cmd: no array access, response cmd 0, `o_err` set until reset.
- Accepted entries shift through a LATENCY-stage valid pipeline, then enter a QDEPTH-entry response FIFO; head drives `mc_rs_*`. Strict in-order.
- `occ` = pipeline valids + FIFO count. `mc_rq_stall` = (occ == QDEPTH) or flush_pend (combinational from registered state). FIFO never overflows; pipeline never stalls.
- Flush FSM: IDLE -> PEND on `mc_rq_flush`; PEND -> DONE when occ == 0; DONE pulses `mc_rs_flush_cmplt` one cycle -> IDLE. Requests stalled in PEND/DONE. Flush pulse while PEND/DONE ignored. Flush with request in same cycle: the request is accepted (stall from prior state) and drained before completion.
- Array contents not reset.

## Timing
- Reset: `mc_rq_stall`=0, `mc_rs_vld`=0, `mc_rs_cmd`/`scmd`/`data`/`rtnctl`=0, `mc_rs_flush_cmplt`=0, `o_err`=0, occ=0, FSM IDLE; in-flight requests discarded. Reset mid-transfer drops all pending responses.
- Accept at cycle T -> `mc_rs_vld` at T+LATENCY if FIFO empty and head not stalled; otherwise later, order preserved.
- Response outputs hold stable while `mc_rs_stall`=1.
- Simultaneous accept and consume at occ==QDEPTH impossible (stall); at occ==QDEPTH-1 both allowed, occ unchanged.
- Back-to-back: one accept and one response per cycle sustained when `mc_rs_stall`=0.
- Flush on idle responder: cmplt pulse at T+2 (PEND at T+1 sees occ 0, DONE at T+2).

## Test plan
- Write 0x1122334455667788 size 3 @0x40 tag 5, then read @0x40 tag 6 -> rs cmd 3 tag 5 at T+4, rs cmd 2 data 0x1122334455667788 tag 6 at T+5.
- Write 0xAB size 0 @0x43 over word 0 -> read @0x40 returns 0x00000000AB000000.
- Hold `mc_rs_stall`=1, issue 10 reads with QDEPTH 8 -> `mc_rq_stall` rises after 8 accepts; release -> 10 responses, tags in issue order, no loss or duplicates.
- Flush with 3 writes in flight -> 3 write-completes, then `mc_rs_flush_cmplt` one cycle after last enters FIFO drains to occ 0; `mc_rq_stall`=1 throughout.
- cmd 5 request -> rs cmd 0, data 0, `o_err`=1 until `i_reset`.
- Assert `i_reset` with 4 in flight -> next cycle all outputs 0, no stale responses afterward.
